// File: rtl/irrigation_pkg.sv
// irrigation_pkg: state/mode encodings and elaboration helpers for the zone scheduler.
// Rev 1.0
`default_nettype none

package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_FILL     = 3'd2,
    ST_IRRIGATE = 3'd3,
    ST_CLEAN    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE      = 2'd0,
    MODE_DRIP      = 2'd1,
    MODE_SPRINKLER = 2'd2
  } mode_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter that decrements on a strobe and saturates at zero.
// Rev 1.0
`default_nettype none

module countdown_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  // Load takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (tick && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

`default_nettype wire

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: round-robin multi-zone FILL/IRRIGATE/CLEAN sequencer sharing one pump.
// Rev 1.0
`default_nettype none

module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int N_ZONES     = 4,
  parameter int ZW          = clog2(N_ZONES),
  parameter int CNT_W       = 7,
  parameter int FILL_S      = 5,
  parameter int SPRINKLER_S = 30,
  parameter int DRIP_S      = 60,
  parameter int CLEAN_S     = 10
) (
  input  logic               clk_50mhz,
  input  logic               init_pulse,
  input  logic               tick_1hz,
  input  logic               run_en,
  input  logic [N_ZONES-1:0] soil_wet_i,
  input  logic [N_ZONES-1:0] air_dry_i,
  input  logic [N_ZONES-1:0] temp_hot_i,
  input  logic               pesticide,
  output logic [N_ZONES-1:0] valve_o,
  output logic               pump_fill_o,
  output logic [1:0]         mode_o,
  output logic [2:0]         state_o,
  output logic [ZW-1:0]      zone_o,
  output logic [CNT_W-1:0]   remaining_s,
  output logic               alert_np,
  output logic               cycle_done
);

  localparam int NC_W = clog2(N_ZONES + 1);

  state_t             state;
  mode_t              mode;
  mode_t              zone_mode;
  logic [ZW-1:0]      zone;
  logic [ZW-1:0]      zone_next;
  logic [NC_W-1:0]    none_cnt;
  logic [N_ZONES-1:0] soil_m, soil_s, air_m, air_s, hot_m, hot_s;
  logic               pest_m, pest_s;
  logic               last_tick, scan_hit, fill_exit, irr_exit, clean_exit;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;

  always_ff @(posedge clk_50mhz) begin
    if (init_pulse) begin
      soil_m <= '0; soil_s <= '0;
      air_m  <= '0; air_s  <= '0;
      hot_m  <= '0; hot_s  <= '0;
      pest_m <= 1'b0; pest_s <= 1'b0;
    end else begin
      soil_m <= soil_wet_i; soil_s <= soil_m;
      air_m  <= air_dry_i;  air_s  <= air_m;
      hot_m  <= temp_hot_i; hot_s  <= hot_m;
      pest_m <= pesticide;  pest_s <= pest_m;
    end
  end

  always_comb begin
    zone_mode = MODE_DRIP;
    if (soil_s[zone])                     zone_mode = MODE_NONE;
    else if (hot_s[zone] || air_s[zone])  zone_mode = MODE_SPRINKLER;
  end

  assign zone_next  = (zone == ZW'(N_ZONES - 1)) ? '0 : zone + ZW'(1);
  assign last_tick  = tick_1hz && (remaining_s == CNT_W'(1));
  assign scan_hit   = (state == ST_SCAN) && run_en && (zone_mode != MODE_NONE);
  assign fill_exit  = (state == ST_FILL) && last_tick;
  // A freshly wet bed ends irrigation even if a tick arrives on the same cycle.
  assign irr_exit   = (state == ST_IRRIGATE) && (soil_s[zone] || last_tick);
  assign clean_exit = (state == ST_CLEAN) && pest_s && last_tick;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = tick_1hz && ((state == ST_FILL) || (state == ST_IRRIGATE) ||
                            ((state == ST_CLEAN) && pest_s));
    if (scan_hit) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(FILL_S);
    end else if (fill_exit) begin
      tmr_load = 1'b1;
      tmr_val  = (mode == MODE_SPRINKLER) ? CNT_W'(SPRINKLER_S) : CNT_W'(DRIP_S);
    end else if (irr_exit) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(CLEAN_S);
    end else if ((state == ST_IDLE) || (state == ST_SCAN)) begin
      tmr_load = 1'b1;
    end
  end

  countdown_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk_50mhz),
    .rst      (init_pulse),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_dec),
    .value    (remaining_s),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_50mhz) begin
    if (init_pulse) begin
      state       <= ST_IDLE;
      zone        <= '0;
      mode        <= MODE_NONE;
      none_cnt    <= '0;
      valve_o     <= '0;
      pump_fill_o <= 1'b0;
      alert_np    <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      alert_np   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run_en) begin
            state    <= ST_SCAN;
            none_cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (!run_en) begin
            state <= ST_IDLE;
          end else begin
            mode <= zone_mode;
            if (scan_hit) begin
              state       <= ST_FILL;
              pump_fill_o <= 1'b1;
              none_cnt    <= '0;
            end else begin
              zone <= zone_next;
              // A whole lap without a thirsty bed ends the scan.
              if (none_cnt == NC_W'(N_ZONES - 1)) begin
                cycle_done <= 1'b1;
                state      <= ST_IDLE;
                none_cnt   <= '0;
              end else begin
                none_cnt <= none_cnt + NC_W'(1);
              end
            end
          end
        end
        ST_FILL: begin
          if (fill_exit) begin
            state       <= ST_IRRIGATE;
            pump_fill_o <= 1'b0;
            valve_o     <= N_ZONES'(1) << zone;
          end
        end
        ST_IRRIGATE: begin
          if (irr_exit) begin
            state   <= ST_CLEAN;
            valve_o <= '0;
          end
        end
        ST_CLEAN: begin
          if (clean_exit) begin
            zone  <= zone_next;
            mode  <= MODE_NONE;
            state <= run_en ? ST_SCAN : ST_IDLE;
          end else begin
            alert_np <= !pest_s;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state;
  assign mode_o  = mode;
  assign zone_o  = zone;

  a_one_outlet: assert property (@(posedge clk_50mhz) disable iff (init_pulse)
    $onehot0({valve_o, pump_fill_o}));

  a_timed_nonzero: assert property (@(posedge clk_50mhz) disable iff (init_pulse)
    (state inside {ST_FILL, ST_IRRIGATE, ST_CLEAN}) |-> !tmr_zero);

endmodule

`default_nettype wire

// File: tb/tb_irrigation_zone_scheduler.sv
// tb_irrigation_zone_scheduler: mode-decode vector table plus scoreboarded state-entry sequences.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_irrigation_zone_scheduler;
  import irrigation_pkg::*;

  logic       clk = 1'b0;
  logic       init_pulse = 1'b0;
  logic       tick = 1'b0;
  logic       run_en = 1'b0;
  logic [3:0] soil = 4'b1111;
  logic [3:0] air = 4'b0000;
  logic [3:0] hot = 4'b0000;
  logic       pest = 1'b1;

  logic [3:0] valve_o;
  logic       pump_fill_o;
  logic [1:0] mode_o;
  logic [2:0] state_o;
  logic [1:0] zone_o;
  logic [6:0] remaining_s;
  logic       alert_np;
  logic       cycle_done;

  irrigation_zone_scheduler dut (
    .clk_50mhz   (clk),
    .init_pulse  (init_pulse),
    .tick_1hz    (tick),
    .run_en      (run_en),
    .soil_wet_i  (soil),
    .air_dry_i   (air),
    .temp_hot_i  (hot),
    .pesticide   (pest),
    .valve_o     (valve_o),
    .pump_fill_o (pump_fill_o),
    .mode_o      (mode_o),
    .state_o     (state_o),
    .zone_o      (zone_o),
    .remaining_s (remaining_s),
    .alert_np    (alert_np),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    int         zone;
    int         mode;
    int         rem;
    int         valve;
    int         pump;
    int         ticks;
    int         cyc;
  } entry_t;

  typedef struct {
    logic       soil;
    logic       air;
    logic       hot;
    logic [1:0] mode;
    logic [2:0] st;
  } vec_t;

  entry_t     exp_q[$];
  vec_t       vt[8];
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_state = 3'd0;
  int         tick_cnt = 0, cyc_cnt = 0, done_cnt = 0, act_cnt = 0;
  int         d0, a0, found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [2:0] st, input int z, input int md, input int rem,
                      input int valve, input int pump, input int tk, input int cy);
    entry_t e;
    e.st = st; e.zone = z; e.mode = md; e.rem = rem;
    e.valve = valve; e.pump = pump; e.ticks = tk; e.cyc = cy;
    exp_q.push_back(e);
  endtask

  // Every cycle: advance, then score any state entry against the head of the queue.
  task automatic step();
    entry_t e;
    logic   ok;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (tick) tick_cnt++;
      cyc_cnt++;
      if (cycle_done) done_cnt++;
      if ((|valve_o) || pump_fill_o) act_cnt++;
      if (state_o != prev_state) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL entry_unexpected: got state %0d zone %0d, expected no transition",
                   state_o, zone_o);
        end else begin
          e  = exp_q.pop_front();
          ok = (state_o == e.st) && (zone_o == e.zone) && (mode_o == e.mode) &&
               (remaining_s == e.rem) && (valve_o == e.valve) && (pump_fill_o == e.pump) &&
               ((e.ticks < 0) || (e.ticks == tick_cnt)) && ((e.cyc < 0) || (e.cyc == cyc_cnt));
          if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL entry: got st=%0d z=%0d m=%0d rem=%0d v=%b p=%b ticks=%0d cyc=%0d; expected st=%0d z=%0d m=%0d rem=%0d v=%0d p=%0d ticks=%0d cyc=%0d",
                     state_o, zone_o, mode_o, remaining_s, valve_o, pump_fill_o, tick_cnt, cyc_cnt,
                     e.st, e.zone, e.mode, e.rem, e.valve, e.pump, e.ticks, e.cyc);
          end
        end
        tick_cnt = 0;
        cyc_cnt  = 0;
      end
    end
    prev_state = state_o;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (9) step();
    end
  endtask

  task automatic do_reset();
    init_pulse = 1'b1;
    step();
    step();
    init_pulse = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, MODE_DRIP,      ST_FILL};
    vt[1] = '{1'b0, 1'b0, 1'b1, MODE_SPRINKLER, ST_FILL};
    vt[2] = '{1'b0, 1'b1, 1'b0, MODE_SPRINKLER, ST_FILL};
    vt[3] = '{1'b0, 1'b1, 1'b1, MODE_SPRINKLER, ST_FILL};
    vt[4] = '{1'b1, 1'b0, 1'b0, MODE_NONE,      ST_IDLE};
    vt[5] = '{1'b1, 1'b0, 1'b1, MODE_NONE,      ST_IDLE};
    vt[6] = '{1'b1, 1'b1, 1'b0, MODE_NONE,      ST_IDLE};
    vt[7] = '{1'b1, 1'b1, 1'b1, MODE_NONE,      ST_IDLE};

    do_reset();
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_zone", zone_o, 0);
    chk("rst_mode", mode_o, MODE_NONE);
    chk("rst_rem", remaining_s, 0);
    chk("rst_valve", valve_o, 0);
    chk("rst_pump", pump_fill_o, 0);
    chk("rst_alert", alert_np, 0);
    chk("rst_done", cycle_done, 0);

    // Mode decode for zone 0, other beds wet.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      soil = {3'b111, vt[i].soil};
      air  = {3'b000, vt[i].air};
      hot  = {3'b000, vt[i].hot};
      repeat (3) step();
      run_en = 1'b1;
      found  = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
        step();
        if ((state_o == ST_FILL) || (cycle_done == 1'b1)) found = 1;
      end
      run_en = 1'b0;
      chk($sformatf("vec%0d_seen", i), found, 1);
      chk($sformatf("vec%0d_state", i), state_o, vt[i].st);
      chk($sformatf("vec%0d_mode", i), mode_o, vt[i].mode);
    end

    air = 4'b0000;
    hot = 4'b0000;
    soil = 4'b1011;
    do_reset();
    repeat (3) step();
    mon_en = 1'b1;

    // Reset while zone 2 irrigates.
    push(ST_SCAN, 0, 0, 0, 0, 0, -1, -1);
    push(ST_FILL, 2, 1, 5, 0, 1, -1, 3);
    push(ST_IRRIGATE, 2, 1, 60, 4'b0100, 0, 5, -1);
    push(ST_IDLE, 0, 0, 0, 0, 0, 3, -1);
    run_en = 1'b1;
    repeat (6) step();
    ticks(5);
    ticks(3);
    chk("t1_valve_on", valve_o, 4'b0100);
    chk("t1_rem", remaining_s, 57);
    init_pulse = 1'b1;
    step();
    chk("t1_valve_off", valve_o, 0);
    chk("t1_state", state_o, ST_IDLE);
    chk("t1_zone", zone_o, 0);
    chk("t1_rem0", remaining_s, 0);
    init_pulse = 1'b0;
    run_en = 1'b0;
    repeat (3) step();
    chk("t1_queue", exp_q.size(), 0);

    // Zone 2 drip cycle.
    push(ST_SCAN, 0, 0, 0, 0, 0, -1, -1);
    push(ST_FILL, 2, 1, 5, 0, 1, -1, 3);
    push(ST_IRRIGATE, 2, 1, 60, 4'b0100, 0, 5, -1);
    push(ST_CLEAN, 2, 1, 10, 0, 0, 60, -1);
    push(ST_IDLE, 3, 0, 0, 0, 0, 10, -1);
    run_en = 1'b1;
    repeat (6) step();
    ticks(5);
    ticks(20);
    chk("t2_rem40", remaining_s, 40);
    ticks(40);
    ticks(9);
    chk("t2_rem1", remaining_s, 1);
    run_en = 1'b0;
    ticks(1);
    chk("t2_queue", exp_q.size(), 0);

    // All beds wet: one empty lap.
    soil = 4'b1111;
    repeat (3) step();
    d0 = done_cnt;
    a0 = act_cnt;
    push(ST_SCAN, 3, 0, 0, 0, 0, -1, -1);
    push(ST_IDLE, 3, 0, 0, 0, 0, -1, 4);
    run_en = 1'b1;
    repeat (5) step();
    run_en = 1'b0;
    repeat (5) step();
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_activity", act_cnt - a0, 0);
    chk("t3_zone", zone_o, 3);
    chk("t3_queue", exp_q.size(), 0);

    // Zone 0 sprinkler, soil turns wet part-way through.
    soil = 4'b1110;
    hot  = 4'b0001;
    repeat (3) step();
    push(ST_SCAN, 3, 0, 0, 0, 0, -1, -1);
    push(ST_FILL, 0, 2, 5, 0, 1, -1, 2);
    push(ST_IRRIGATE, 0, 2, 30, 4'b0001, 0, 5, -1);
    push(ST_CLEAN, 0, 2, 10, 0, 0, 12, -1);
    push(ST_IDLE, 1, 0, 0, 0, 0, 17, -1);
    run_en = 1'b1;
    repeat (5) step();
    ticks(5);
    ticks(12);
    chk("t4_rem18", remaining_s, 18);
    soil = 4'b1111;
    run_en = 1'b0;
    step();
    step();
    chk("t4_still_irr", state_o, ST_IRRIGATE);
    step();
    chk("t4_clean", state_o, ST_CLEAN);
    chk("t4_clean_rem", remaining_s, 10);

    // Pesticide outage freezes CLEAN.
    pest = 1'b0;
    repeat (4) step();
    chk("t5_alert_on", alert_np, 1);
    ticks(7);
    chk("t5_frozen", remaining_s, 10);
    chk("t5_alert_hold", alert_np, 1);
    pest = 1'b1;
    repeat (4) step();
    chk("t5_alert_off", alert_np, 0);
    ticks(10);
    chk("t5_queue", exp_q.size(), 0);

    // Zone 3 with pointer wrap; run_en drops during FILL.
    soil = 4'b0111;
    air  = 4'b1000;
    hot  = 4'b0000;
    repeat (3) step();
    push(ST_SCAN, 1, 0, 0, 0, 0, -1, -1);
    push(ST_FILL, 3, 2, 5, 0, 1, -1, 3);
    push(ST_IRRIGATE, 3, 2, 30, 4'b1000, 0, 5, -1);
    push(ST_CLEAN, 3, 2, 10, 0, 0, 30, -1);
    push(ST_IDLE, 0, 0, 0, 0, 0, 10, -1);
    run_en = 1'b1;
    repeat (6) step();
    ticks(2);
    run_en = 1'b0;
    ticks(3);
    ticks(30);
    ticks(10);
    chk("t6_zone_wrap", zone_o, 0);
    chk("t6_idle", state_o, ST_IDLE);
    chk("t6_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
